// File: rtl/cbrt_feeder.sv
// Operand sequencer in front of a multi-cycle cube-root unit: buffers operands in a
// small FIFO, launches them one at a time and returns {operand, root} pairs in order.
module cbrt_feeder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_x,
    output logic [2:0]    out_root,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    cbrt_x,
    output logic          cbrt_start,
    input  logic          cbrt_busy,
    input  logic [2:0]    cbrt_result,
    output logic [AW:0]   level
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [7:0]      op_q, op_d;
    logic            start_q, start_d;
    logic [7:0]      out_x_q, out_x_d;
    logic [2:0]      out_root_q, out_root_d;
    logic            out_valid_q, out_valid_d;

    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic            slot_free_s;

    // Handshake qualifiers derived from registered state only.
    always_comb begin
        full_s      = (level_q == LVL_FULL);
        push_s      = in_valid && !full_s;
        slot_free_s = !out_valid_q || out_ready;
    end

    // Launch sequencer: pop on IDLE->START, capture in WAIT once busy drops and slot is free.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((level_q != LVL_ZERO) && !cbrt_busy) begin
                    state_d = ST_START;
                    pop_s   = 1'b1;
                    op_d    = mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cbrt_busy && slot_free_s) begin
                    capture_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_d = (state_d == ST_START);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Output slot: a capture wins over the clear so back-to-back results have no bubble.
    always_comb begin
        out_x_d     = out_x_q;
        out_root_d  = out_root_q;
        out_valid_d = out_valid_q;
        if (capture_s) begin
            out_valid_d = 1'b1;
            out_x_d     = op_q;
            out_root_d  = cbrt_result;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= LVL_ZERO;
            op_q        <= 8'h00;
            start_q     <= 1'b0;
            out_x_q     <= 8'h00;
            out_root_q  <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            op_q        <= op_d;
            start_q     <= start_d;
            out_x_q     <= out_x_d;
            out_root_q  <= out_root_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = !full_s;
    assign level      = level_q;
    assign cbrt_x     = op_q;
    assign cbrt_start = start_q;
    assign out_x      = out_x_q;
    assign out_root   = out_root_q;
    assign out_valid  = out_valid_q;

endmodule

// File: doc/cbrt_feeder.md
# cbrt_feeder

Operand sequencer placed directly upstream of `cbrt`. It accepts a stream of 8-bit operands over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to `cbrt` through its `start`/`busy` handshake, and returns each 3-bit root, paired with its operand, over a second valid/ready handshake. Its purpose is to keep `cbrt` busy under bursty input and to decouple the producer and consumer from `cbrt`'s variable latency.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `AW`, 2: FIFO address width; `AW = log2(DEPTH)`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserting it (0) clears all state immediately.
- `in_data`  in  8  operand.
- `in_valid`  in  1  producer has an operand on `in_data`.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `out_x`  out  8  operand that produced `out_root`.
- `out_root`  out  3  floor cube root of `out_x`.
- `out_valid`  out  1  output slot holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `cbrt_x`  out  8  drives `cbrt.x_i`.
- `cbrt_start`  out  1  drives `cbrt.start`.
- `cbrt_busy`  in  1  from `cbrt.busy`.
- `cbrt_result`  in  3  from `cbrt.result`.
- `level`  out  AW+1  current FIFO occupancy, 0..DEPTH.

## Operation
- **Push:** occurs on an edge where `in_valid && in_ready`.
  - `in_ready` is registered-state only; there is no combinational path from `out_ready` or the pop to `in_ready`.
- **Pop:** occurs only on the IDLE→START edge.
  - The head entry is copied into the operand register `op_q`, which drives `cbrt_x`.
  - `cbrt_x` holds `op_q` until the next pop.
- **Simultaneous push and pop:** `level` is unchanged and both pointers advance.
  - At full, a push is refused even if a pop happens in the same cycle.
- **Pointers:** `AW` bits each, wrapping modulo DEPTH. `level` is a separate counter.
- **FSM, IDLE:**
  - Moves to START when `level != 0 && !cbrt_busy`.
  - Otherwise stays in IDLE.
- **FSM, START:**
  - `cbrt_start = 1` for exactly this one cycle.
  - Unconditionally moves to WAIT.
- **FSM, WAIT:**
  - While `cbrt_busy = 1`: stay in WAIT.
  - When `cbrt_busy = 0` and the output slot is free: capture `{op_q, cbrt_result}` into `{out_x, out_root}`, set `out_valid`, and go to IDLE.
  - The output slot is free when `out_valid = 0`, or when `out_valid && out_ready` in that same cycle.
  - When `cbrt_busy = 0` and the slot is not free: stay in WAIT. `cbrt` holds its result stable while idle and not restarted.
- **Output slot:**
  - `out_valid` is cleared on `out_valid && out_ready`, unless a capture happens in the same cycle, in which case it stays 1 with the new data.
  - `out_x` and `out_root` are stable while `out_valid && !out_ready`.
- **`cbrt` contract:**
  - `start` is sampled on the rising edge.
  - `busy` is 1 from the edge that samples `start` until the result is valid.
- **Ordering:** results emerge in push order; nothing is dropped or duplicated.
- **Reset** (`rst = 0`, at any time, including mid-conversion):
  - State → IDLE; pointers and `level` → 0; `op_q` → 0.
  - `out_valid` → 0; `out_x` and `out_root` → 0; `cbrt_start` → 0.
  - `in_ready` = 1 once out of reset.
  - A conversion in flight is abandoned. `cbrt` is not reset by this block. IDLE's `!cbrt_busy` guard prevents a new start until `cbrt` is idle.

## Timing
- The FSM occupies one cycle in IDLE and one in START; WAIT occupies cycles until `cbrt_busy` falls.
- **Push to start:** push at edge E0 → `level = 1` after E0 → IDLE→START at E1 → `cbrt_start` high E1..E2 → `cbrt` samples at E2 → WAIT.
- **Capture:** on the first edge in WAIT with `cbrt_busy = 0` and the slot free; `out_valid` is high after that edge.
  - Best-case push-to-`out_valid` latency is 3 cycles plus `cbrt`'s busy duration.
- **Back-to-back:** minimum spacing between successive `cbrt_start` pulses is busy duration + 3 cycles (START→WAIT, capture, IDLE→START).
- **Throughput:** one result per launch; the producer sustains a push every cycle until `level = DEPTH`.
- **Capacity with `out_ready = 0`:** accepted operands before `in_ready` falls = DEPTH + 2 (one in the output slot, one parked in WAIT, DEPTH in the FIFO).

## Test plan
- **Single operand:** reset, push 27 → exactly one `cbrt_start` pulse with `cbrt_x = 27`; `out_valid` rises with `out_x = 27`, `out_root = 3`; after handshake `level = 0` and `out_valid = 0`.
- **Burst in order:** push 1, 8, 64, 255 on consecutive cycles with `out_ready = 1` → outputs `(1,1)`, `(8,2)`, `(64,4)`, `(255,6)` in that order; exactly 4 start pulses.
- **Backpressure / full:** `out_ready = 0`, `in_valid = 1` continuously with values 0..9.
  - Exactly 6 values (0..5) accepted; `in_ready = 0` with `level = 4`; `out_x = 0` held stable.
  - Then `out_ready = 1` → outputs 0..5 in order with roots 0,1,1,1,1,1.
- **Wrap-around and push at full:** 12 operands pushed with random `out_valid` stalls → all 12 results correct and in order; no push is accepted while `level = 4`, even in a pop cycle.
- **Reset mid-conversion:** push 216, assert `rst` low while in WAIT → all outputs immediately at reset values; after release with `cbrt_busy` still 1, no `cbrt_start` until busy falls; subsequent push 125 → `out_root = 5`.
- **Output-slot overlap:** capture in the same cycle as `out_valid && out_ready` → `out_valid` stays 1 and the new data appears with no bubble.
